// File: rtl/alu_muldiv_if.sv
// Handshake and result bundle between the EX-stage pipeline and the ALU/mul-div unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface alu_muldiv_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic [WIDTH-1:0]   result;
   logic               zero;
   logic               overflow;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               busy;

   modport master (
      output in_valid, op, a, b, shamt,
      input  in_ready, out_valid, result, zero, overflow, hi, lo, busy
   );

   modport slave (
      input  in_valid, op, a, b, shamt,
      output in_ready, out_valid, result, zero, overflow, hi, lo, busy
   );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Registered MIPS-style ALU with an iterative shift-add multiplier and restoring divider
// that commit into architectural HI/LO; single-cycle ops issue back-to-back from IDLE.
module alu_muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic          clk,
   input logic          reset_n,
   alu_muldiv_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_SLT   = 4'd6;
   localparam logic [3:0] OP_SLTU  = 4'd7;
   localparam logic [3:0] OP_SLL   = 4'd8;
   localparam logic [3:0] OP_SRL   = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;
   localparam logic [3:0] OP_MULT  = 4'd11;
   localparam logic [3:0] OP_MULTU = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [3:0] OP_DIVU  = 4'd14;
   localparam logic [3:0] OP_MFHL  = 4'd15;

   localparam logic [SHAMT_W-1:0] LAST_BIT = SHAMT_W'(WIDTH - 1);

   state_t               state;
   state_t               next_state;
   logic [SHAMT_W-1:0]   cnt;
   logic [WIDTH-1:0]     acc_hi;
   logic [WIDTH-1:0]     acc_lo;
   logic [WIDTH-1:0]     operand;
   logic [WIDTH-1:0]     dividend;
   logic [WIDTH-1:0]     result_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic                 neg_q;
   logic                 neg_r;
   logic                 div_zero;
   logic                 is_div;
   logic                 out_valid_q;
   logic                 zero_q;
   logic                 overflow_q;

   logic                 accept;
   logic                 is_mul_op;
   logic                 is_div_op;
   logic                 signed_op;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH-1:0]     sum;
   logic [WIDTH-1:0]     diff;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_ovf;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       trial;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     quot;
   logic [WIDTH-1:0]     rem;

   assign accept    = bus.in_valid && (state == IDLE);
   assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
   assign is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign a_neg     = signed_op && bus.a[WIDTH-1];
   assign b_neg     = signed_op && bus.b[WIDTH-1];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: iterative ops run exactly WIDTH steps, then one sign-fix cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept && is_mul_op) begin
               next_state = MUL;
            end else if (accept && is_div_op) begin
               next_state = DIV;
            end
         end
         MUL, DIV: begin
            if (cnt == LAST_BIT) begin
               next_state = FIX;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Single-cycle ALU results, computed directly from the bus operands
   always_comb begin
      sum     = bus.a + bus.b;
      diff    = bus.a - bus.b;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_NOR:  alu_res = ~(bus.a | bus.b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_SLL:  alu_res = bus.b << bus.shamt;
         OP_SRL:  alu_res = bus.b >> bus.shamt;
         OP_SRA:  alu_res = $signed(bus.b) >>> bus.shamt;
         OP_MFHL: alu_res = bus.b[0] ? lo_q : hi_q;
         default: alu_res = '0;
      endcase
   end

   // One multiply/divide step plus the signed corrections applied in FIX
   always_comb begin
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      trial   = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, operand};
      product = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quot    = neg_q ? -acc_lo : acc_lo;
      rem     = neg_r ? -acc_hi : acc_hi;
   end

   // Datapath: MUL keeps {acc_hi,acc_lo} as partial product over multiplier;
   // DIV keeps acc_hi as remainder and acc_lo as dividend shifting into quotient
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt         <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         operand     <= '0;
         dividend    <= '0;
         result_q    <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         div_zero    <= 1'b0;
         is_div      <= 1'b0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt <= '0;
                  if (is_mul_op || is_div_op) begin
                     neg_q    <= a_neg ^ b_neg;
                     neg_r    <= a_neg;
                     is_div   <= is_div_op;
                     div_zero <= (bus.b == '0);
                     dividend <= bus.a;
                     acc_hi   <= '0;
                     acc_lo   <= is_div_op ? a_mag : b_mag;
                     operand  <= is_div_op ? b_mag : a_mag;
                  end else begin
                     result_q    <= alu_res;
                     zero_q      <= (alu_res == '0);
                     overflow_q  <= alu_ovf;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
            end
            DIV: begin
               if (!trial[WIDTH]) begin
                  acc_hi <= trial[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               result_q    <= '0;
               zero_q      <= 1'b1;
               overflow_q  <= 1'b0;
               out_valid_q <= 1'b1;
               if (!is_div) begin
                  hi_q <= product[2*WIDTH-1:WIDTH];
                  lo_q <= product[WIDTH-1:0];
               end else if (div_zero) begin
                  // Divide by zero is defined, not trapped: all-ones quotient, dividend as remainder
                  lo_q <= '1;
                  hi_q <= dividend;
               end else begin
                  lo_q <= quot;
                  hi_q <= rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state == MUL) || (state == DIV);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = overflow_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule
